// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: sequences DIV/DIVU/MTHI/MTLO against a multicycle divider and owns the HI/LO registers
module hilo_div_ctrl (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_ena,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_div_start,
    output logic        o_div_signed,
    output logic [31:0] o_div_dividend,
    output logic [31:0] o_div_divisor,
    input  logic [31:0] i_div_q,
    input  logic [31:0] i_div_r,
    input  logic        i_div_busy
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
    state_t r_state, w_next;
    logic [31:0] r_hi, r_lo, r_dividend, r_divisor;
    logic        r_signed;
    logic        w_idle, w_is_div, w_accept, w_mthi, w_mtlo;
    assign w_idle         = r_state == IDLE;
    assign w_is_div       = i_ena && (i_op == 3'b001 || i_op == 3'b010);
    assign w_accept       = w_idle && w_is_div && i_rt_data != '0;
    assign w_mthi         = w_idle && i_ena && i_op == 3'b011;
    assign w_mtlo         = w_idle && i_ena && i_op == 3'b100;
    assign o_hi           = r_hi;
    assign o_lo           = r_lo;
    assign o_div_signed   = r_signed;
    assign o_div_dividend = r_dividend;
    assign o_div_divisor  = r_divisor;
    // state register; reset aborts any divide in flight
    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    // next state plus stall/start/done; a zero divisor is consumed without launching
    always_comb begin
        w_next      = r_state;
        o_stall     = 1'b0;
        o_done      = 1'b0;
        o_div_start = 1'b0;
        case (r_state)
            IDLE: begin
                w_next  = w_accept ? LAUNCH : IDLE;
                o_stall = w_accept;
            end
            LAUNCH: begin
                w_next      = WAIT;
                o_stall     = 1'b1;
                o_div_start = 1'b1;
            end
            WAIT: begin
                w_next  = i_div_busy ? WAIT : IDLE;
                o_stall = i_div_busy;
                o_done  = !i_div_busy;
            end
            default: w_next = IDLE;
        endcase
    end
    // operands are captured only on accept, so they stay frozen until the result returns
    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_signed   <= 1'b0;
        end else if (w_accept) begin
            r_dividend <= i_rs_data;
            r_divisor  <= i_rt_data;
            r_signed   <= i_op == 3'b001;
        end
    // HI takes the remainder and LO the quotient; MTHI/MTLO only land while idle
    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (o_done) begin
            r_hi <= i_div_r;
            r_lo <= i_div_q;
        end else begin
            if (w_mthi) r_hi <= i_rs_data;
            if (w_mtlo) r_lo <= i_rs_data;
        end
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl: directed bench with a 32-cycle divider model and a HI/LO scoreboard
module tb_hilo_div_ctrl;
    logic        clk = 1'b0, rst = 1'b1, ena = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] rs = '0, rt = '0;
    logic [31:0] hi, lo, dd, dv, q, r;
    logic        stall, done, start, sgn, busy;
    logic [5:0]  cnt;
    int          errors = 0, checks = 0;
    typedef struct {logic [31:0] hi; logic [31:0] lo;} res_t;
    res_t        sb[$];

    localparam logic [2:0] OP_DIV = 3'b001, OP_DIVU = 3'b010, OP_MTHI = 3'b011, OP_MTLO = 3'b100;

    hilo_div_ctrl dut (
        .i_clock(clk), .i_reset(rst), .i_ena(ena), .i_op(op), .i_rs_data(rs), .i_rt_data(rt),
        .o_hi(hi), .o_lo(lo), .o_stall(stall), .o_done(done), .o_div_start(start),
        .o_div_signed(sgn), .o_div_dividend(dd), .o_div_divisor(dv),
        .i_div_q(q), .i_div_r(r), .i_div_busy(busy)
    );

    always #5 clk = ~clk;

    // divider model: busy for 32 cycles after start, result taken from live operands at the end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            q    <= '0;
            r    <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= 6'd32;
        end else if (cnt != 0) begin
            cnt  <= cnt - 1'b1;
            busy <= cnt != 6'd1;
            if (cnt == 6'd1) begin
                if (sgn) begin
                    q <= $signed(dd) / $signed(dv);
                    r <= $signed(dd) % $signed(dv);
                end else begin
                    q <= dd / dv;
                    r <= dd % dv;
                end
            end
        end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // runs one divide from C0 (caller is just after a posedge) and leaves the bench at the C35 negedge
    task automatic do_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic wiggle, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic mtlo_after, input logic [31:0] mval);
        int   cyc = 0, stalls = 0, starts = 0;
        logic got = 1'b0;
        res_t exp_r;
        sb.push_back('{ehi, elo});
        ena = 1'b1; op = o; rs = a; rt = b;
        while (!got && cyc < 100) begin
            @(negedge clk);
            if (stall) stalls++;
            if (start) begin
                starts++;
                check("start_cycle", cyc, 1);
            end
            if (cyc == 1) check("div_signed", {31'b0, sgn}, {31'b0, s});
            if (cyc >= 1 && cyc <= 34) begin
                check("dividend_stable", dd, a);
                check("divisor_stable", dv, b);
            end
            if (done) begin
                got = 1'b1;
                check("done_cycle", cyc, 34);
            end
            step();
            cyc++;
            if (wiggle && cyc >= 1 && cyc <= 33) begin
                rs = $urandom;
                rt = $urandom;
            end
        end
        check("done_seen", {31'b0, got}, 32'd1);
        check("stall_cycles", stalls, 34);
        check("start_pulses", starts, 1);
        ena = mtlo_after; op = mtlo_after ? OP_MTLO : 3'b000; rs = mval;
        @(negedge clk);
        exp_r = sb.pop_front();
        check("result_hi", hi, exp_r.hi);
        check("result_lo", lo, exp_r.lo);
        check("c35_stall", {31'b0, stall}, 32'd0);
        check("c35_done", {31'b0, done}, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_stall", {31'b0, stall}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_start", {31'b0, start}, 0);
        check("rst_signed", {31'b0, sgn}, 0);
        check("rst_dividend", dd, 0);
        check("rst_divisor", dv, 0);
        step();
        rst = 1'b0;
        step();

        // signed divide followed by an MTLO in C35 that overwrites LO
        do_div(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 32'hCAFEF00D);
        step();
        ena = 1'b0;
        @(negedge clk);
        check("b2b_lo", lo, 32'hCAFEF00D);
        check("b2b_hi", hi, 32'hFFFFFFFF);
        step();

        do_div(OP_DIVU, 32'hFFFFFFFF, 32'h10, 1'b0, 1'b0, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 32'h0);
        step();

        // divide by zero with preloaded HI/LO
        ena = 1'b1; op = OP_MTHI; rs = 32'h11;
        step();
        op = OP_MTLO; rs = 32'h22;
        step();
        op = OP_DIV; rs = 32'd5; rt = 32'd0;
        @(negedge clk);
        check("dz_stall", {31'b0, stall}, 0);
        check("dz_start", {31'b0, start}, 0);
        check("dz_done", {31'b0, done}, 0);
        step();
        ena = 1'b0; op = 3'b000;
        @(negedge clk);
        check("dz_start_next", {31'b0, start}, 0);
        check("dz_hi", hi, 32'h11);
        check("dz_lo", lo, 32'h22);
        step();

        // MTHI then MTLO on consecutive cycles
        ena = 1'b1; op = OP_MTHI; rs = 32'hDEADBEEF;
        @(negedge clk);
        check("mthi_stall", {31'b0, stall}, 0);
        step();
        op = OP_MTLO; rs = 32'h12345678;
        @(negedge clk);
        check("mthi_hi", hi, 32'hDEADBEEF);
        check("mtlo_stall", {31'b0, stall}, 0);
        step();
        ena = 1'b0; op = 3'b000;
        @(negedge clk);
        check("mtlo_lo", lo, 32'h12345678);
        check("mthi_hold", hi, 32'hDEADBEEF);
        step();

        // reset in C10 of a divide
        ena = 1'b1; op = OP_DIV; rs = 32'd100; rt = 32'd7;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1; ena = 1'b0; op = 3'b000;
        @(negedge clk);
        check("mid_rst_hi", hi, 0);
        check("mid_rst_lo", lo, 0);
        check("mid_rst_stall", {31'b0, stall}, 0);
        check("mid_rst_start", {31'b0, start}, 0);
        check("mid_rst_done", {31'b0, done}, 0);
        check("mid_rst_signed", {31'b0, sgn}, 0);
        check("mid_rst_dividend", dd, 0);
        check("mid_rst_divisor", dv, 0);
        step();
        rst = 1'b0;
        step();
        do_div(OP_DIV, 32'd100, 32'd7, 1'b1, 1'b0, 32'd2, 32'd14, 1'b0, 32'h0);
        step();

        // operands wiggle upstream during the divide
        do_div(OP_DIV, 32'hFFFFFF9C, 32'd3, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFDF, 1'b0, 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hilo_div_ctrl.md
# hilo_div_ctrl

Sequencer between the decode/execute stage and the multicycle divider units. Accepts DIV, DIVU, MTHI and MTLO operations, launches the divider with stable operands, and stalls the pipeline until the quotient and remainder are ready. Writes the results into the architectural HI/LO registers and holds those registers for MFHI/MFLO reads.

## Interface
No parameters.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- ena  in  1  instruction in execute stage is valid
- op  in  3  000 none, 001 DIV, 010 DIVU, 011 MTHI, 100 MTLO; 101–111 treated as none
- rs_data  in  32  rs operand (dividend / MTHI/MTLO source)
- rt_data  in  32  rt operand (divisor)
- hi  out  32  HI register, for MFHI
- lo  out  32  LO register, for MFLO
- stall  out  1  freeze upstream pipeline (combinational)
- done  out  1  one-cycle pulse when HI/LO are written by a divide
- div_start  out  1  one-cycle start pulse to the divider
- div_signed  out  1  1 selects the signed divider, 0 selects the unsigned divider; external mux routes q/r/busy
- div_dividend  out  32  latched dividend
- div_divisor  out  32  latched divisor
- div_q  in  32  quotient from the selected divider
- div_r  in  32  remainder from the selected divider
- div_busy  in  1  selected divider busy

## Operation
- FSM states: IDLE, LAUNCH, WAIT.
- IDLE:
  - ena=1 and op=DIV/DIVU with rt_data≠0: latch rs_data→div_dividend and rt_data→div_divisor. Set div_signed (1 for DIV). Go to LAUNCH. stall=1 this cycle.
  - ena=1 and op=DIV/DIVU with rt_data=0: no launch, HI/LO unchanged, stall=0. The op is consumed as a no-op.
  - ena=1 and op=MTHI: hi<=rs_data at the clock edge, stall=0.
  - ena=1 and op=MTLO: lo<=rs_data at the clock edge, stall=0.
  - ena=0 or op=none: hold.
- LAUNCH: div_start=1 for exactly one cycle, stall=1, then go to WAIT.
- WAIT:
  - div_busy=1: stall=1, stay in WAIT.
  - div_busy=0: stall=0, done=1, lo<=div_q, hi<=div_r, then go to IDLE.
- div_dividend, div_divisor and div_signed stay constant from the latch edge until the result is captured. The divider derives its result sign from live operand inputs, so any change in that window is forbidden.
- div_start is never asserted outside LAUNCH and never held for two cycles; a held start re-initialises the divider.
- Ops other than the one being executed are not sampled outside IDLE. Upstream holds ena/op stable while stall=1.
- Reset, asynchronous and taking effect at any state including mid-divide:
  - state=IDLE, hi=0, lo=0, div_start=0, done=0, div_signed=0.
  - div_dividend=0, div_divisor=0.
  - The divider shares the same reset.

## Timing
- C0: IDLE accepts the divide. stall=1, operands latched at the end of C0.
- C1: LAUNCH. div_start=1, stall=1. The divider samples start at the end of C1.
- C2–C33: div_busy=1 (32 iteration cycles), stall=1.
- C34: div_busy=0. stall=0, done=1, HI/LO written at the end of C34.
- C35: new hi/lo visible. An MFHI/MFLO here reads the result.
- Total stall: 34 cycles (C0–C33). Divide latency from accept to visible result: 35 cycles.
- MTHI/MTLO: zero stall. Value visible the cycle after the write.
- Divide by zero: zero stall, no div_start, done stays 0.
- Back-to-back: a divide followed by MTLO. The MTLO is presented in C35 and completes in IDLE; it overwrites the divide's LO.

## Test plan
- DIV rs=0xFFFFFFF9 (−7), rt=2 -> div_signed=1. stall high exactly C0–C33, done at C34, lo=0xFFFFFFFD, hi=0xFFFFFFFF at C35.
- DIVU rs=0xFFFFFFFF, rt=0x10, with an unsigned divider model on the mux -> div_signed=0, lo=0x0FFFFFFF, hi=0x0000000F, same cycle counts.
- DIV rs=5, rt=0 with hi/lo preloaded 0x11/0x22 -> no div_start, stall=0, done=0, hi=0x11, lo=0x22 unchanged.
- MTHI 0xDEADBEEF, then MTLO 0x12345678 on consecutive cycles -> no stall; hi=0xDEADBEEF and lo=0x12345678 each visible the cycle after its write.
- DIV 100/7 with reset asserted in C10 -> hi=lo=0, stall=0, state IDLE immediately. A new DIV 100/7 after release gives lo=14, hi=2 with full 35-cycle latency.
- Operand stability: during DIV −100/3, change rs_data/rt_data every cycle C1–C33 -> div_dividend/div_divisor stay constant, lo=0xFFFFFFDF (−33), hi=0xFFFFFFFF (−1).
